// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: width defaults, opcode names,
// FSM state type and the legal-opcode helper used by the optional check.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CODE_W_DEF = 5;

    // Arithmetic group
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_ADDU  = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SUBU  = 5'b00011;
    localparam logic [4:0] OP_NEG   = 5'b00100;
    localparam logic [4:0] OP_CMP   = 5'b00101;
    // Logic group
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_OR    = 5'b01001;
    localparam logic [4:0] OP_XOR   = 5'b01010;
    localparam logic [4:0] OP_NOT   = 5'b01100;
    // Shift group
    localparam logic [4:0] OP_SHL   = 5'b10000;
    localparam logic [4:0] OP_SHR   = 5'b10001;
    localparam logic [4:0] OP_SAR   = 5'b10010;
    localparam logic [4:0] OP_ROL   = 5'b10011;
    // Multiply / compare group
    localparam logic [4:0] OP_MUL   = 5'b11000;
    localparam logic [4:0] OP_MULH  = 5'b11001;
    localparam logic [4:0] OP_DIV   = 5'b11010;
    localparam logic [4:0] OP_REM   = 5'b11011;
    localparam logic [4:0] OP_CMPEQ = 5'b11100;
    localparam logic [4:0] OP_CMPNE = 5'b11101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when the opcode belongs to one of the implemented groups.
    // Wider opcode fields are legal only with their upper bits clear.
    function automatic logic op_legal(input logic [31:0] c);
        logic lo;
        lo = (c[4:0] <= 5'd5) ||
             (c[4:0] >= 5'd8  && c[4:0] <= 5'd10) ||
             (c[4:0] == 5'd12) ||
             (c[4:0] >= 5'd16 && c[4:0] <= 5'd19) ||
             (c[4:0] >= 5'd24 && c[4:0] <= 5'd29);
        return lo && (c[31:5] == '0);
    endfunction

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. A lone request always wins; on contention the
// pointed-to requester wins. After any grant the pointer moves to the other one.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    // Pointer update: point away from whoever was just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ptr <= 1'b0;
        else if (advance) ptr <= gnt[0];
    end

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !ptr)) gnt = 2'b01;
        else if (req[1])                 gnt = 2'b10;
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester scheduler for one shared combinational ALU.
// Flow: IDLE (grant + register operands) -> EXEC (capture result) -> RESP
// (hold response until rsp_ready). Define ALU_SCHED_OPCHECK_EN to reject
// unimplemented opcodes with rsp_err instead of forwarding them.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [CODE_W-1:0] req0_code,
    input  logic [CODE_W-1:0] req1_code,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CODE_W-1:0] alu_code,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_tag,
    output logic [DATA_W-1:0] rsp_c,
    output logic              rsp_overflow,
    output logic              busy
`ifdef ALU_SCHED_OPCHECK_EN
    ,
    output logic              rsp_err
`endif
);

    state_t            state, state_nx;
    logic [1:0]        gnt;
    logic              take;
    logic              sel;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [CODE_W-1:0] sel_code;
    logic              code_ok;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .advance (take),
        .gnt     (gnt)
    );

    assign sel      = gnt[1];
    assign sel_a    = sel ? req1_a    : req0_a;
    assign sel_b    = sel ? req1_b    : req0_b;
    assign sel_code = sel ? req1_code : req0_code;

`ifdef ALU_SCHED_OPCHECK_EN
    logic err_pend;
    assign code_ok = op_legal(32'(sel_code));
`else
    assign code_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and grant acceptance
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            ST_IDLE: if (|gnt) begin
                take     = 1'b1;
                state_nx = ST_EXEC;
            end
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign req0_ready = take & gnt[0];
    assign req1_ready = take & gnt[1];
    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);

    // Issue: latch granted operands toward the ALU; opcode only if accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_code <= '0;
            rsp_tag  <= 1'b0;
        end else if (take) begin
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            rsp_tag <= sel;
            if (code_ok) alu_code <= sel_code;
        end
    end

    // Result capture in EXEC; rejected opcodes report a zero result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_c        <= '0;
            rsp_overflow <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_c        <= alu_c;
            rsp_overflow <= alu_overflow;
`ifdef ALU_SCHED_OPCHECK_EN
            if (err_pend) begin
                rsp_c        <= '0;
                rsp_overflow <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_SCHED_OPCHECK_EN
    // Error tracking: flagged at grant, shown with the response, cleared on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pend <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (take) err_pend <= !code_ok;
            if (state == ST_EXEC) rsp_err <= err_pend;
            else if (state == ST_RESP && rsp_ready) rsp_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter CODE_W, default 5, ALU opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester has an operation pending.
REQ-006 SHALL have ports req0_code/req1_code  input  CODE_W each  requested ALU opcode.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W each  operands.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1 each  request accepted this cycle.
REQ-009 SHALL have ports alu_a, alu_b  output  DATA_W  and alu_code  output  CODE_W  registered drive to the shared ALU.
REQ-010 SHALL have ports alu_c  input  DATA_W  and alu_overflow  input  1  combinational ALU result.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_tag  output  1 (requester index), rsp_c  output  DATA_W, rsp_overflow  output  1, busy  output  1 (state != IDLE).

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-013 In IDLE, if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally, register its a/b/code into alu_a/alu_b/alu_code and its index into rsp_tag, go to EXEC.
REQ-014 Arbitration SHALL be round-robin: a single valid requester always wins; if both valid, the requester pointed to by priority pointer wins; pointer then points to the other requester.
REQ-015 reqN_ready SHALL be 0 outside IDLE and for the non-granted requester.
REQ-016 In EXEC (exactly one cycle), SHALL capture alu_c into rsp_c and alu_overflow into rsp_overflow, go to RESP.
REQ-017 In RESP, rsp_valid SHALL be 1 and rsp_c/rsp_overflow/rsp_tag SHALL hold stable until rsp_ready=1; on that edge go to IDLE.
REQ-018 Latency: accept at edge N, rsp_valid high from edge N+2; minimum 3 cycles per operation (no overlap).
REQ-019 alu_a/alu_b/alu_code SHALL hold last issued values in RESP and IDLE.
REQ-020 Requester SHALL hold valid/operands stable until ready; dropping valid before ready is legal and forfeits the request.
REQ-021 Overflow SHALL be forwarded unmodified; scheduler performs no arithmetic.

Reset
REQ-022 On rst: state IDLE, alu_a=0, alu_b=0, alu_code=0, rsp_valid=0, rsp_c=0, rsp_overflow=0, rsp_tag=0, priority pointer=0 (req0 first), busy=0.
REQ-023 Reset during EXEC or RESP SHALL abort the operation; no response delivered.

Configuration
REQ-024 With ALU_SCHED_OPCHECK_EN defined, a granted opcode outside {00000-00101, 01000-01010, 01100, 10000-10011, 11000-11101} SHALL complete with rsp_c=0, rsp_overflow=0 and output rsp_err=1 (1 bit, 0 otherwise, reset 0); alu_code SHALL NOT be updated for it.
REQ-025 Without ALU_SCHED_OPCHECK_EN, all opcodes SHALL be forwarded unchecked and rsp_err SHALL not exist.

Structure
REQ-026 Shared package alu_pkg SHALL hold DATA_W/CODE_W defaults, named opcode constants, and the FSM state typedef.
REQ-027 Arbitration SHALL be a sub-module rr_arb2 (2 requests, pointer, grant one-hot, advance input).

Verification
REQ-028 req0 only: code 00000, a=7F00, b=0300, ALU model attached -> req0_ready at N, rsp_valid at N+2, rsp_c=8200, rsp_overflow=1, rsp_tag=0.
REQ-029 Both valid from reset: req0 code 00001 (0001+0001), req1 code 11100 (0705,0705) -> req0 served first (rsp_c=0002, tag 0), then req1 (rsp_c=0001, tag 1).
REQ-030 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready 0, busy 1; rsp_ready=1 -> IDLE next edge.
REQ-031 rst pulsed while in EXEC -> all outputs at reset values, no rsp_valid, next request served with tag per pointer=0.
REQ-032 With ALU_SCHED_OPCHECK_EN: code 00110 -> rsp_err=1, rsp_c=0000, alu_code unchanged; without macro -> alu_code=00110 forwarded.
REQ-033 Back-to-back req1 only, 4 ops -> each served, 3-cycle spacing, pointer alternation never blocks a lone requester.
